dbg_display_ctrl: RTL and testbench
===================================

Name: dbg_display_ctrl

Overview:
- Parametrised debug-word selector and hex display driver for the board top level; successor to the fixed 8-way debug mux plus four hex-digit decoders.
- Takes NCH packed W-bit debug words from the processor (PC/state, ALU A/B/out, RF words, datapath mux), selects one, and drives NDIG active-low 7-segment digits.
- Channel selection is manual, auto-scrolling, or auto-scrolling over a channel mask.
- A freeze toggle holds a snapshot of the displayed word while the processor keeps running.

Parameters:
- W, 16, debug word width; must equal 4*NDIG
- NDIG, 4, number of hex digits driven
- NCH, 8, number of debug channels (2..2**SELW)
- SELW, 3, select/channel index width
- DWELL, 50000000, clock cycles each channel is shown in the auto modes (>=2)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous active-high reset
- sel  in  SELW  manual channel select (board switches)
- mode  in  2  00 manual, 01 auto-scroll, 10 masked auto-scroll, 11 treated as manual
- ch_en  in  NCH  channel enable mask for mode 10
- freeze  in  1  level input (switch or debounced key); each rising edge toggles frozen
- dbg_bus  in  NCH*W  packed channels; channel k = dbg_bus[k*W +: W]
- hex_out  out  NDIG*7  digit d = hex_out[d*7 +: 7] shows word nibble d; active-low, bit0=a … bit6=g
- cur_ch  out  SELW  channel currently selected (registered)
- ch_valid  out  1  1 when cur_ch < NCH and a channel is being shown
- frozen  out  1  1 while the snapshot is displayed

Behaviour:
- Reset (async, asserted) values:
  - cur_ch=0, dwell counter=0, frozen=0, snapshot=0, freeze edge register=0
  - ch_valid=0; hex_out = all ones (all digits blank)
  - Normal operation starts on the first rising edge after reset deasserts.
- Segment code, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - blank=1111111
- Manual mode (00/11):
  - cur_ch <= sel every cycle, so latency sel->cur_ch is 1 cycle.
  - Dwell counter held at 0.
- Auto mode (01):
  - Dwell counter increments each cycle.
  - At DWELL-1 the counter clears to 0 and cur_ch advances by 1, wrapping from NCH-1 to 0.
- Masked auto mode (10):
  - Same dwell timing as mode 01.
  - On advance, cur_ch moves to the next index with ch_en=1, searching upward with wrap. Chosen within one cycle via a combinational priority search.
  - If the only enabled channel is cur_ch, cur_ch is unchanged.
  - If ch_en is all zero: cur_ch held, ch_valid=0, display blank.
- Mode change:
  - Any cycle where mode differs from its previous registered value clears the dwell counter.
  - Auto modes resume from the current cur_ch.
  - Entering mode 10 on a disabled channel keeps it until the first advance.
- Out-of-range channel:
  - When cur_ch >= NCH, ch_valid=0 and every digit is blank.
  - Auto modes never generate cur_ch >= NCH; if one is already held, the next advance wraps to 0 (or to the first enabled channel in mode 10).
- Display path:
  - hex_out registered from the decoded word of cur_ch, and ch_valid registered alongside it.
  - Latency: dbg_bus->hex_out is 1 cycle; sel->hex_out is 2 cycles.
- Freeze:
  - Rising edge detected against the previous registered freeze value; each rising edge toggles frozen.
  - On the 0->1 toggle, snapshot <= the word being displayed that cycle (post-blank word held as 0 with a blank flag).
  - While frozen=1, hex_out decodes the snapshot. dbg_bus, sel and mode changes do not alter the display, but cur_ch keeps updating.
  - On release, the live display is restored the next cycle.
  - freeze held high does not re-toggle.
- Reset mid-operation: everything returns immediately to the reset values, including clearing frozen and the snapshot.

Test Plan:
- Reset, then mode=00, sel=3, channel3=16'h1A2F -> cur_ch=3 after 1 edge; hex_out digits 3..0 = 1111001,0001000,0100100,0001110 after 2 edges; ch_valid=1.
- NCH=6, sel=7 -> ch_valid=0, hex_out all ones; then sel=0 with channel0=16'h0000 -> all digits 1000000.
- DWELL=4, mode=01 from cur_ch=0 -> cur_ch steps 0,1,2,…,NCH-1,0 every 4 cycles; switching to 00 mid-dwell makes cur_ch follow sel next cycle.
- DWELL=4, mode=10, ch_en=8'b1000_0101 -> sequence 0,2,7,0; ch_en=0 -> cur_ch held, ch_valid=0, display blank.
- Channel2=16'h00BE shown, freeze 0->1 -> frozen=1; change channel2 to 16'hFFFF and sel=5 -> display stays 00BE; freeze 1->0 (no effect) then 0->1 -> frozen=0, display shows channel5 next cycle.
- Assert reset while frozen in mode 01 with counter mid-dwell -> immediately frozen=0, cur_ch=0, hex_out all ones; after release, the counter restarts from 0.

Source files
------------

// File: rtl/dbg_display_ctrl.sv
// Debug-word selector and hex display driver.
// Picks one of NCH packed debug words (manual, auto-scroll or masked auto-scroll),
// decodes it onto NDIG active-low 7-segment digits, and can freeze a snapshot.
module dbg_display_ctrl #(
    parameter int unsigned W     = 16,
    parameter int unsigned NDIG  = 4,
    parameter int unsigned NCH   = 8,
    parameter int unsigned SELW  = 3,
    parameter int unsigned DWELL = 50000000
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [SELW-1:0]   i_sel,
    input  logic [1:0]        i_mode,
    input  logic [NCH-1:0]    i_ch_en,
    input  logic              i_freeze,
    input  logic [NCH*W-1:0]  i_dbg_bus,
    output logic [NDIG*7-1:0] o_hex_out,
    output logic [SELW-1:0]   o_cur_ch,
    output logic              o_ch_valid,
    output logic              o_frozen
);

    localparam int unsigned   CW       = $clog2(DWELL);
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
    localparam logic [SELW:0] NCH_W    = (SELW + 1)'(NCH);
    localparam logic [SELW:0] LAST_CH  = (SELW + 1)'(NCH - 1);

    logic [SELW-1:0]   r_cur_ch;
    logic [CW-1:0]     r_cnt;
    logic [1:0]        r_mode;
    logic              r_freeze;
    logic              r_frozen;
    logic [W-1:0]      r_snap_word;
    logic              r_snap_blank;
    logic [W-1:0]      r_disp_word;
    logic              r_disp_valid;
    logic [NDIG*7-1:0] r_hex;

    logic              w_masked;
    logic              w_auto;
    logic              w_mode_chg;
    logic              w_in_range;
    logic              w_live_valid;
    logic [W-1:0]      w_live_word;
    logic [SELW-1:0]   w_base;
    logic [SELW-1:0]   w_next_inc;
    logic [SELW-1:0]   w_next_masked;
    logic [SELW-1:0]   w_hi;
    logic [SELW-1:0]   w_lo;
    logic              w_hi_found;
    logic              w_lo_found;
    logic              w_rise;
    logic              w_take_snap;
    logic              w_frozen_d;
    logic [W-1:0]      w_snap_word_d;
    logic              w_snap_blank_d;
    logic [W-1:0]      w_show_word;
    logic              w_show_valid;
    logic [NDIG*7-1:0] w_hex_d;

    function automatic logic [6:0] f_seg(input logic [3:0] n);
        case (n)
            4'h0:    f_seg = 7'b1000000;
            4'h1:    f_seg = 7'b1111001;
            4'h2:    f_seg = 7'b0100100;
            4'h3:    f_seg = 7'b0110000;
            4'h4:    f_seg = 7'b0011001;
            4'h5:    f_seg = 7'b0010010;
            4'h6:    f_seg = 7'b0000010;
            4'h7:    f_seg = 7'b1111000;
            4'h8:    f_seg = 7'b0000000;
            4'h9:    f_seg = 7'b0010000;
            4'hA:    f_seg = 7'b0001000;
            4'hB:    f_seg = 7'b0000011;
            4'hC:    f_seg = 7'b1000110;
            4'hD:    f_seg = 7'b0100001;
            4'hE:    f_seg = 7'b0000110;
            default: f_seg = 7'b0001110;
        endcase
    endfunction

    assign w_masked   = (i_mode == 2'b10);
    assign w_auto     = (i_mode == 2'b01) || w_masked;
    assign w_mode_chg = (i_mode != r_mode);
    assign w_in_range = ({1'b0, r_cur_ch} < NCH_W);
    // An empty mask in masked mode means nothing is being shown.
    assign w_live_valid = w_in_range && !(w_masked && (i_ch_en == '0));

    // Select the live word of the current channel.
    always_comb begin
        w_live_word = '0;
        for (int k = 0; k < int'(NCH); k++) begin
            if (r_cur_ch == SELW'(k)) w_live_word = i_dbg_bus[k*W +: W];
        end
    end

    // Next channel for the auto modes; an out-of-range channel searches from index 0.
    always_comb begin
        w_base     = w_in_range ? r_cur_ch : LAST_CH[SELW-1:0];
        w_next_inc = ({1'b0, w_base} == LAST_CH) ? '0 : w_base + SELW'(1);
        w_hi       = '0;
        w_lo       = '0;
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        // Walking downward leaves the lowest enabled index in each half.
        for (int k = int'(NCH) - 1; k >= 0; k--) begin
            if (i_ch_en[k]) begin
                if (SELW'(k) > w_base) begin
                    w_hi       = SELW'(k);
                    w_hi_found = 1'b1;
                end else begin
                    w_lo       = SELW'(k);
                    w_lo_found = 1'b1;
                end
            end
        end
        w_next_masked = w_hi_found ? w_hi : (w_lo_found ? w_lo : r_cur_ch);
    end

    // Channel selection and dwell timing.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cur_ch <= '0;
            r_cnt    <= '0;
            r_mode   <= 2'b00;
        end else begin
            r_mode <= i_mode;
            if (!w_auto) begin
                r_cnt    <= '0;
                r_cur_ch <= i_sel;
            end else if (w_mode_chg) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt    <= '0;
                r_cur_ch <= w_masked ? w_next_masked : w_next_inc;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign w_rise         = i_freeze & ~r_freeze;
    assign w_take_snap    = w_rise & ~r_frozen;
    assign w_frozen_d     = r_frozen ^ w_rise;
    // The snapshot captures what is on the digits right now, blanks included.
    assign w_snap_word_d  = w_take_snap ? (r_disp_valid ? r_disp_word : '0) : r_snap_word;
    assign w_snap_blank_d = w_take_snap ? ~r_disp_valid : r_snap_blank;
    assign w_show_word    = w_frozen_d ? w_snap_word_d : w_live_word;
    assign w_show_valid   = w_frozen_d ? ~w_snap_blank_d : w_live_valid;

    // Decode the word to be shown into segment patterns.
    always_comb begin
        w_hex_d = '1;
        for (int d = 0; d < int'(NDIG); d++) begin
            if (w_show_valid) w_hex_d[d*7 +: 7] = f_seg(w_show_word[d*4 +: 4]);
        end
    end

    // Freeze edge detection and snapshot storage.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_freeze     <= 1'b0;
            r_frozen     <= 1'b0;
            r_snap_word  <= '0;
            r_snap_blank <= 1'b0;
        end else begin
            r_freeze     <= i_freeze;
            r_frozen     <= w_frozen_d;
            r_snap_word  <= w_snap_word_d;
            r_snap_blank <= w_snap_blank_d;
        end
    end

    // Registered display path.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_hex        <= '1;
            r_disp_word  <= '0;
            r_disp_valid <= 1'b0;
        end else begin
            r_hex        <= w_hex_d;
            r_disp_word  <= w_show_valid ? w_show_word : '0;
            r_disp_valid <= w_show_valid;
        end
    end

    assign o_hex_out  = r_hex;
    assign o_cur_ch   = r_cur_ch;
    assign o_ch_valid = r_disp_valid;
    assign o_frozen   = r_frozen;

endmodule

// File: tb/tb_dbg_display_ctrl.sv
// Self-checking bench for dbg_display_ctrl: an 8-channel and a 6-channel instance.
module tb_dbg_display_ctrl;

    localparam int unsigned W     = 16;
    localparam int unsigned NDIG  = 4;
    localparam int unsigned SELW  = 3;
    localparam int unsigned DWELL = 4;

    localparam logic [27:0] BLANK    = {4{7'b1111111}};
    localparam logic [27:0] ALL_ZERO = {4{7'b1000000}};
    localparam logic [27:0] HEX_00BE = {7'b1000000, 7'b1000000, 7'b0000011, 7'b0000110};
    localparam logic [27:0] HEX_C0DE = {7'b1000110, 7'b1000000, 7'b0100001, 7'b0000110};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]   sel;
    logic [1:0]   mode;
    logic [7:0]   ch_en;
    logic         freeze;
    logic [127:0] dbg;
    logic [27:0]  hex;
    logic [2:0]   cur;
    logic         valid;
    logic         frozen;

    logic [2:0]   sel6;
    logic [1:0]   mode6;
    logic [5:0]   en6;
    logic         frz6;
    logic [95:0]  dbg6;
    logic [27:0]  hex6;
    logic [2:0]   cur6;
    logic         valid6;
    logic         frozen6;

    dbg_display_ctrl #(.W(W), .NDIG(NDIG), .NCH(8), .SELW(SELW), .DWELL(DWELL)) u_dut (
        .i_clock(clk), .i_reset(rst), .i_sel(sel), .i_mode(mode), .i_ch_en(ch_en),
        .i_freeze(freeze), .i_dbg_bus(dbg), .o_hex_out(hex), .o_cur_ch(cur),
        .o_ch_valid(valid), .o_frozen(frozen)
    );

    dbg_display_ctrl #(.W(W), .NDIG(NDIG), .NCH(6), .SELW(SELW), .DWELL(DWELL)) u_dut6 (
        .i_clock(clk), .i_reset(rst), .i_sel(sel6), .i_mode(mode6), .i_ch_en(en6),
        .i_freeze(frz6), .i_dbg_bus(dbg6), .o_hex_out(hex6), .o_cur_ch(cur6),
        .o_ch_valid(valid6), .o_frozen(frozen6)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [2:0]  cur;
        logic [27:0] hex;
        logic        valid;
    } exp_t;

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] word;
        logic [27:0] hex;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard monitor: compare queued expectations once they fall due.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                check("sb_cur", 32'(cur), 32'(e.cur));
                check("sb_hex", 32'(hex), 32'(e.hex));
                check("sb_valid", 32'(valid), 32'(e.valid));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int idx;
        int exp_seq[3];

        vecs[0] = '{3'd3, 16'h1A2F, {7'b1111001, 7'b0001000, 7'b0100100, 7'b0001110}};
        vecs[1] = '{3'd0, 16'h0000, {4{7'b1000000}}};
        vecs[2] = '{3'd7, 16'h89AB, {7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011}};
        vecs[3] = '{3'd5, 16'hC0DE, {7'b1000110, 7'b1000000, 7'b0100001, 7'b0000110}};
        vecs[4] = '{3'd1, 16'h3456, {7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010}};
        vecs[5] = '{3'd6, 16'h7E9D, {7'b1111000, 7'b0000110, 7'b0010000, 7'b0100001}};

        sel = '0; mode = 2'b00; ch_en = '0; freeze = 1'b0; dbg = '0;
        sel6 = '0; mode6 = 2'b00; en6 = '0; frz6 = 1'b0; dbg6 = '0;

        // Reset state
        tick(2);
        check("rst_hex", 32'(hex), 32'(BLANK));
        check("rst_cur", 32'(cur), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_frozen", 32'(frozen), 0);
        check("rst_hex6", 32'(hex6), 32'(BLANK));
        rst = 1'b0;
        tick(1);

        // Manual-mode vectors through the scoreboard
        for (int i = 0; i < 6; i++) begin
            idx = int'(vecs[i].sel);
            sel = vecs[i].sel;
            dbg[idx*W +: W] = vecs[i].word;
            sb.push_back('{cyc + 2, vecs[i].sel, vecs[i].hex, 1'b1});
            tick(2);
        end
        tick(1);
        check("sb_drained", 32'(sb.size()), 0);

        // Six-channel instance: out-of-range select blanks, wrap from out of range
        sel6 = 3'd7;
        tick(2);
        check("oor_valid", 32'(valid6), 0);
        check("oor_hex", 32'(hex6), 32'(BLANK));
        sel6 = 3'd0;
        tick(2);
        check("ch0_hex", 32'(hex6), 32'(ALL_ZERO));
        check("ch0_valid", 32'(valid6), 1);
        sel6 = 3'd7;
        tick(1);
        check("oor_cur", 32'(cur6), 7);
        mode6 = 2'b01;
        tick(5);
        check("oor_wrap", 32'(cur6), 0);
        tick(4);
        check("nch6_step", 32'(cur6), 1);
        tick(16);
        check("nch6_last", 32'(cur6), 5);
        tick(4);
        check("nch6_wrap", 32'(cur6), 0);

        // Auto-scroll over all eight channels
        sel = 3'd0; mode = 2'b00;
        tick(1);
        mode = 2'b01;
        tick(1);
        for (int s = 1; s <= 8; s++) begin
            tick(4);
            check("auto_step", 32'(cur), 32'(s % 8));
        end
        tick(2);
        mode = 2'b00; sel = 3'd5;
        tick(1);
        check("auto_to_manual", 32'(cur), 5);

        // Masked auto-scroll
        sel = 3'd0;
        tick(1);
        mode = 2'b10; ch_en = 8'b1000_0101;
        tick(1);
        exp_seq = '{2, 7, 0};
        for (int s = 0; s < 3; s++) begin
            tick(4);
            check("mask_step", 32'(cur), 32'(exp_seq[s]));
        end
        tick(1);
        check("mask_valid", 32'(valid), 1);
        ch_en = 8'h00;
        tick(1);
        check("mask_empty_valid", 32'(valid), 0);
        check("mask_empty_hex", 32'(hex), 32'(BLANK));
        tick(8);
        check("mask_empty_hold", 32'(cur), 0);
        ch_en = 8'h01;
        tick(8);
        check("mask_self_hold", 32'(cur), 0);
        check("mask_self_valid", 32'(valid), 1);

        // Freeze
        mode = 2'b00; sel = 3'd2; dbg[2*W +: W] = 16'h00BE;
        tick(2);
        check("frz_live", 32'(hex), 32'(HEX_00BE));
        freeze = 1'b1;
        tick(1);
        check("frz_on", 32'(frozen), 1);
        check("frz_on_hex", 32'(hex), 32'(HEX_00BE));
        dbg[2*W +: W] = 16'hFFFF; sel = 3'd5;
        tick(3);
        check("frz_hold_hex", 32'(hex), 32'(HEX_00BE));
        check("frz_cur_moves", 32'(cur), 5);
        freeze = 1'b0;
        tick(2);
        check("frz_fall", 32'(frozen), 1);
        check("frz_fall_hex", 32'(hex), 32'(HEX_00BE));
        freeze = 1'b1;
        tick(1);
        check("frz_off", 32'(frozen), 0);
        check("frz_off_hex", 32'(hex), 32'(HEX_C0DE));

        // Reset while frozen, mid-dwell in auto mode
        mode = 2'b01;
        tick(1);
        freeze = 1'b0;
        tick(1);
        freeze = 1'b1;
        tick(1);
        check("pre_rst_frozen", 32'(frozen), 1);
        rst = 1'b1; freeze = 1'b0;
        #1;
        check("mid_rst_frozen", 32'(frozen), 0);
        check("mid_rst_cur", 32'(cur), 0);
        check("mid_rst_hex", 32'(hex), 32'(BLANK));
        check("mid_rst_valid", 32'(valid), 0);
        @(negedge clk);
        rst = 1'b0;
        tick(3);
        check("post_rst_cnt", 32'(cur), 0);
        tick(2);
        check("post_rst_step", 32'(cur), 1);
        check("post_rst_frozen", 32'(frozen), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
